// File: rtl/alu_seq_unit_pkg.sv
// alu_pkg: opcode codes shared by the ALU control decoder and the execute-stage
// ALU, the FSM state encoding of alu_seq_unit, and a small opcode classifier.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h8;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'hA;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'hE;
  localparam logic [3:0] ALU_SRA  = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: request/response bundle between the operand mux (master)
// and the execute-stage ALU (slave).
//   Start_i, Ex_aluop_i, Op_a_i, Op_b_i : request, driven by the master
//   Ready_o, Done_o, Result_o, Zero_o  : status/result, driven by the ALU
interface alu_seq_unit_if #(
  parameter int XLEN = 32
);
  logic            Start_i;
  logic [3:0]      Ex_aluop_i;
  logic [XLEN-1:0] Op_a_i;
  logic [XLEN-1:0] Op_b_i;
  logic            Ready_o;
  logic            Done_o;
  logic [XLEN-1:0] Result_o;
  logic            Zero_o;

  modport master (
    output Start_i, Ex_aluop_i, Op_a_i, Op_b_i,
    input  Ready_o, Done_o, Result_o, Zero_o
  );

  modport slave (
    input  Start_i, Ex_aluop_i, Op_a_i, Op_b_i,
    output Ready_o, Done_o, Result_o, Zero_o
  );
endinterface

// File: rtl/alu_comb_ops.sv
// alu_comb_ops: purely combinational single-cycle RV32I operations
// (add, sub, xor, or, and, slt, sltu). Shift codes and unused codes give 0.
//   aluop  : opcode from ALU control
//   op_a   : operand A
//   op_b   : operand B
//   result : operation result
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      aluop,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = op_a;
  assign b_s = op_b;

  always_comb begin
    result = '0;
    case (aluop)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: execute-stage ALU. Logic/arithmetic/compare ops complete in one
// cycle; shifts run on a serial one-bit-per-cycle shifter.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : alu_seq_unit_if slave (Start/opcode/operands in, Ready/Done/Result/Zero out)
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_seq_unit_if.slave bus
);

  state_t          state_q;
  state_t          state_d;
  logic            ready;
  logic            accept;
  logic            shift_req;
  logic            last_step;
  logic [SHW-1:0]  amt;
  logic [SHW-1:0]  cnt_q;
  logic [3:0]      shop_q;
  logic [XLEN-1:0] shreg_q;
  logic [XLEN-1:0] shreg_nxt;
  logic [XLEN-1:0] comb_res;
  logic [XLEN-1:0] load_res;
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  // One step of the serial shifter; sra keeps re-inserting the original sign,
  // which stays in the MSB for the whole shift.
  function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] v,
                                                 input logic [3:0] op);
    case (op)
      ALU_SLL: return {v[XLEN-2:0], 1'b0};
      ALU_SRA: return {v[XLEN-1], v[XLEN-1:1]};
      default: return {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

  alu_comb_ops #(.XLEN(XLEN)) u_comb (
    .aluop  (bus.Ex_aluop_i),
    .op_a   (bus.Op_a_i),
    .op_b   (bus.Op_b_i),
    .result (comb_res)
  );

  assign amt       = bus.Op_b_i[SHW-1:0];
  assign shift_req = is_shift(bus.Ex_aluop_i) && (amt != '0);
  assign accept    = bus.Start_i && ready;
  assign last_step = (state_q == ST_SHIFT) && (cnt_q == SHW'(1));
  assign shreg_nxt = shift_step(shreg_q, shop_q);
  // A shift by zero returns operand A unchanged in the accept cycle.
  assign load_res  = is_shift(bus.Ex_aluop_i) ? bus.Op_a_i : comb_res;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = shift_req ? ST_SHIFT : ST_DONE;
        else        state_d = ST_IDLE;
      end
      ST_SHIFT: if (last_step) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready       = (state_q != ST_SHIFT);
    bus.Ready_o = ready;
    bus.Done_o  = (state_q == ST_DONE);
  end

  // Stage boundary: result, zero flag and shift counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      cnt_q    <= '0;
    end else if (accept) begin
      if (shift_req) begin
        cnt_q <= amt;
      end else begin
        result_q <= load_res;
        zero_q   <= (load_res == '0);
      end
    end else if (state_q == ST_SHIFT) begin
      cnt_q <= cnt_q - SHW'(1);
      if (last_step) begin
        result_q <= shreg_nxt;
        zero_q   <= (shreg_nxt == '0);
      end
    end
  end

  // Stage boundary: serial shift register (data only, no reset needed).
  always_ff @(posedge clk_i) begin
    if (accept && shift_req) begin
      shreg_q <= bus.Op_a_i;
      shop_q  <= bus.Ex_aluop_i;
    end else if (state_q == ST_SHIFT) begin
      shreg_q <= shreg_nxt;
    end
  end

  assign bus.Result_o = result_q;
  assign bus.Zero_o   = zero_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  alu_seq_unit_if #(.XLEN(32)) ifc ();

  alu_seq_unit #(.XLEN(32), .SHW(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int k;
    k = int'(b[4:0]);
    case (op)
      4'h8: return a + b;
      4'h1: return a - b;
      4'h5: return a ^ b;
      4'h6: return a | b;
      4'h4: return a & b;
      4'h9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hA: return (a < b) ? 32'd1 : 32'd0;
      4'h7: return a << k;
      4'hE: return a >> k;
      4'hD: return $signed(a) >>> k;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural model: an accepted op yields its value after a latency of
  // 1 (single-cycle or zero shift) or k+1 (shift by k); busy while waiting.
  logic        m_ready = 1'b1;
  logic        m_done  = 1'b0;
  logic [31:0] m_res   = 32'd0;
  logic [31:0] m_val   = 32'd0;
  int          m_left  = 0;

  always @(posedge clk or posedge rst) begin
    logic [31:0] v;
    int          k;
    if (rst) begin
      m_ready = 1'b1; m_done = 1'b0; m_res = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = 1'b0;
      if (m_left == 0) begin
        m_res = m_val; m_done = 1'b1; m_ready = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (ifc.Start_i) begin
        v = ref_alu(ifc.Ex_aluop_i, ifc.Op_a_i, ifc.Op_b_i);
        k = (ifc.Ex_aluop_i == 4'h7 || ifc.Ex_aluop_i == 4'hE || ifc.Ex_aluop_i == 4'hD)
            ? int'(ifc.Op_b_i[4:0]) : 0;
        if (k == 0) begin
          m_res = v; m_done = 1'b1;
        end else begin
          m_left = k; m_val = v; m_ready = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_ready",  {31'd0, ifc.Ready_o}, {31'd0, m_ready});
      chk("model_done",   {31'd0, ifc.Done_o},  {31'd0, m_done});
      chk("model_result", ifc.Result_o, m_res);
      chk("model_zero",   {31'd0, ifc.Zero_o},  {31'd0, (m_res == 32'd0)});
    end
  end

  // Issue one op from a ready state, measure latency, check literal result.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input int exp_lat);
    int n;
    int w;
    w = 0;
    while (!ifc.Ready_o && w < 40) begin
      @(posedge clk); #1; w++;
    end
    chk({name, "_ready_wait"}, {31'd0, ifc.Ready_o}, 32'd1);
    ifc.Start_i = 1'b1; ifc.Ex_aluop_i = op; ifc.Op_a_i = a; ifc.Op_b_i = b;
    @(posedge clk); #1;
    ifc.Start_i = 1'b0; ifc.Op_a_i = $urandom; ifc.Op_b_i = $urandom;
    n = 1;
    while (!ifc.Done_o && n < 40) begin
      chk({name, "_ready_busy"}, {31'd0, ifc.Ready_o}, 32'd0);
      @(posedge clk); #1; n++;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_result"}, ifc.Result_o, exp_res);
    chk({name, "_zero"}, {31'd0, ifc.Zero_o}, {31'd0, exp_zero});
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, {31'd0, ifc.Done_o}, 32'd0);
    chk({name, "_hold"}, ifc.Result_o, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [31:0] b;
    rst = 1'b1;
    ifc.Start_i = 1'b0; ifc.Ex_aluop_i = 4'h0; ifc.Op_a_i = 32'd0; ifc.Op_b_i = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready",  {31'd0, ifc.Ready_o}, 32'd1);
    chk("rst_done",   {31'd0, ifc.Done_o},  32'd0);
    chk("rst_result", ifc.Result_o, 32'd0);
    chk("rst_zero",   {31'd0, ifc.Zero_o},  32'd1);

    run_op("add_wrap", 4'h8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
    run_op("sub_eq",   4'h1, 32'd5, 32'd5, 32'd0, 1'b1, 1);
    run_op("xor_ne",   4'h5, 32'd5, 32'd4, 32'd1, 1'b0, 1);
    run_op("slt",      4'h9, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1);
    run_op("sltu",     4'hA, 32'h8000_0000, 32'd1, 32'd0, 1'b1, 1);
    run_op("and",      4'h4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
    run_op("bad_op",   4'h0, 32'h1234_5678, 32'h9, 32'd0, 1'b1, 1);
    run_op("sra31",    4'hD, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 32);
    run_op("srl31",    4'hE, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 32);
    run_op("sll3",     4'h7, 32'h0000_0003, 32'hFFFF_FFE3, 32'h0000_0018, 1'b0, 4);
    run_op("sll0",     4'h7, 32'd1, 32'h20, 32'd1, 1'b0, 1);

    // Start held high through a long shift, reset pulsed mid-shift.
    ifc.Start_i = 1'b1; ifc.Ex_aluop_i = 4'h7; ifc.Op_a_i = 32'd1; ifc.Op_b_i = 32'd10;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready",  {31'd0, ifc.Ready_o}, 32'd1);
    chk("abort_done",   {31'd0, ifc.Done_o},  32'd0);
    chk("abort_result", ifc.Result_o, 32'd0);
    chk("abort_zero",   {31'd0, ifc.Zero_o},  32'd1);
    @(posedge clk); #1;
    rst = 1'b0; ifc.Start_i = 1'b0;
    seen = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (ifc.Done_o) seen++;
    end
    chk("abort_no_done", seen, 0);

    // Back-to-back single-cycle ops.
    ifc.Start_i = 1'b1; ifc.Ex_aluop_i = 4'h8; ifc.Op_a_i = 32'h10; ifc.Op_b_i = 32'h22;
    @(posedge clk); #1;
    chk("b2b_add_done",   {31'd0, ifc.Done_o}, 32'd1);
    chk("b2b_add_result", ifc.Result_o, 32'h32);
    ifc.Ex_aluop_i = 4'h6; ifc.Op_a_i = 32'hF0; ifc.Op_b_i = 32'h0F;
    @(posedge clk); #1;
    chk("b2b_or_done",   {31'd0, ifc.Done_o}, 32'd1);
    chk("b2b_or_result", ifc.Result_o, 32'hFF);
    chk("b2b_or_zero",   {31'd0, ifc.Zero_o}, 32'd0);
    ifc.Start_i = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_done", {31'd0, ifc.Done_o}, 32'd0);

    // Randomized traffic, including Start during SHIFT and unused codes.
    repeat (3000) begin
      ifc.Start_i    = ($urandom_range(0, 2) != 0);
      ifc.Ex_aluop_i = 4'($urandom_range(0, 15));
      ifc.Op_a_i     = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b[4:0] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) b = ifc.Op_a_i;
      ifc.Op_b_i = b;
      @(posedge clk); #1;
    end
    ifc.Start_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Execute-stage ALU that consumes the 4-bit `Ex_aluop` code produced by the ALU control decoder and computes the RV32I integer result. Logic/arithmetic/compare ops finish in one cycle. Shifts use a serial one-bit-per-cycle shifter to save area on the FPGA build. It sits between the register-file/immediate mux and the writeback/branch logic, and returns `Zero_o` for beq/bne resolution.

## Interface
- `XLEN`, default 32: datapath width.
- `SHW`, default 5: shift-amount width, equal to log2(XLEN).
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `Start_i` input 1: operation request; sampled on rising edge.
- `Ex_aluop_i` input 4: opcode from ALU control.
- `Op_a_i` input XLEN: operand A.
- `Op_b_i` input XLEN: operand B. For shifts, `Op_b_i[SHW-1:0]` is the shift amount.
- `Ready_o` output 1: unit can accept `Start_i` this cycle.
- `Done_o` output 1: one-cycle pulse; `Result_o`/`Zero_o` are valid and new.
- `Result_o` output XLEN: registered result.
- `Zero_o` output 1: registered `(Result_o == 0)`.

## Operation
- Opcode map:
  - 8 add, 1 sub, 5 xor, 6 or, 4 and.
  - 9 slt (signed), A sltu.
  - 7 sll, E srl, D sra.
  - All other codes, including 0: result 0, `Zero_o`=1, latency 1, no error flag.
- Add/sub: modulo 2^XLEN, carry discarded. slt/sltu: result is 1 or 0, zero-extended.
- Shifts: sll/srl fill with 0. sra fills with `Op_a_i[XLEN-1]`. Bits of `Op_b_i` above `SHW` are ignored.
- Branch use: sub with `Zero_o`=1 means beq taken. xor with `Zero_o`=0 means bne taken.
- FSM states:
  - IDLE: `Ready_o`=1.
  - SHIFT: `Ready_o`=0.
  - DONE: `Ready_o`=1, `Done_o`=1.
- Accept condition: `Start_i && Ready_o` at a rising edge. Operands and opcode are captured at that edge; later input changes have no effect.
- Non-shift op, or shift with amount 0: result is written at the accept edge, next state is DONE.
- Shift with amount k>0: operand is loaded into the shift register and the counter is set to k; next state is SHIFT. Each SHIFT edge shifts one bit and decrements the counter. When the counter reaches 0, the final value is written to `Result_o` and the state moves to DONE.
- DONE with no accept: next state is IDLE.
- DONE with an accept: back-to-back start, handled as from IDLE. `Done_o` is 0 in the following cycle unless the new op is single-cycle, in which case it stays 1 for the new result.
- `Start_i` while in SHIFT is ignored and not queued.
- `Result_o`/`Zero_o` hold between `Done_o` pulses.
- Reset values: state IDLE, `Ready_o`=1, `Done_o`=0, `Result_o`=0, `Zero_o`=1, counter 0. `Start_i` has no effect while `rst_i`=1.
- Reset mid-SHIFT: aborts immediately. No `Done_o`; `Result_o` returns to 0.

## Timing
- Latency is measured from the accept edge to the cycle in which `Done_o`=1.
- Single-cycle ops and zero shifts: latency 1, i.e. the cycle immediately after the accept edge.
- Shift by k: latency k+1. Worst case at XLEN=32 is 32 cycles.
- Throughput: one single-cycle op per clock via the back-to-back path.
- `Ready_o` and `Done_o` are decoded from registered state only; there is no combinational path from inputs to outputs.

## Structure
- Package `alu_pkg`:
  - Opcode localparams: `ALU_ADD`=4'h8, `ALU_SUB`=4'h1, `ALU_XOR`=4'h5, `ALU_OR`=4'h6, `ALU_AND`=4'h4, `ALU_SLT`=4'h9, `ALU_SLTU`=4'hA, `ALU_SLL`=4'h7, `ALU_SRL`=4'hE, `ALU_SRA`=4'hD.
  - FSM state encoding.
- Sub-module `alu_comb_ops`: purely combinational single-cycle ops (add through sltu, plus the invalid-code default).
- Top level holds the FSM, shift register, counter and output registers.

## Test plan
- Reset release, then check outputs → `Ready_o`=1, `Done_o`=0, `Result_o`=0, `Zero_o`=1.
- add A=0xFFFFFFFF, B=1 → after 1 cycle: `Result_o`=0, `Zero_o`=1, `Done_o` pulses once.
- sub A=5, B=5 → `Zero_o`=1. xor A=5, B=4 → `Result_o`=1, `Zero_o`=0.
- slt A=0x80000000, B=1 → 1. sltu with the same operands → 0.
- Shifts:
  - sra A=0x80000000, B=31 → `Done_o` 32 cycles after accept, `Result_o`=0xFFFFFFFF, `Ready_o`=0 throughout SHIFT.
  - srl with the same operands → 0x00000001.
  - sll A=1, B=0x20 (amount 0) → 1, latency 1.
- `Start_i` held high during a B=10 sll, then `rst_i` pulsed at cycle 5 → no `Done_o`, state IDLE. Next, back-to-back add/or ops → `Done_o` high on consecutive cycles with correct results.
